// File: rtl/imem_responder.sv
// imem_responder: instruction-fetch responder backed by a small direct-mapped
// line buffer. Hits respond one cycle after acceptance. A miss issues one
// 4-beat x 64-bit burst, installs the line, then responds.
//
// Optional build macro: IMEM_CRITICAL_WORD_EN. When it is defined, a miss
// responds the cycle after the beat holding the requested word arrives.
// When it is undefined, a miss responds only after the whole line is filled.
//
// Ports:
//   clk, rst          clock; synchronous active-low reset (rst==0 resets)
//   imem_addr/rmask   fetch request (valid when rmask != 0)
//   flush             branch redirect; blocks accept, cancels pending resp
//   imem_rdata/resp   one-cycle response pulse with the instruction word
//   bmem_addr/read    line-aligned burst request, held until bmem_ready
//   bmem_ready        burst request accept
//   bmem_rdata/rvalid returned beats, in order 0..3, possibly with gaps
module imem_responder #(
  parameter int unsigned NUM_LINES  = 4,
  parameter int unsigned LINE_BEATS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  input  logic        flush,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  output logic [31:0] bmem_addr,
  output logic        bmem_read,
  input  logic        bmem_ready,
  input  logic [63:0] bmem_rdata,
  input  logic        bmem_rvalid
);
  localparam int unsigned IDX_W  = $clog2(NUM_LINES);
  localparam int unsigned TAG_W  = 32 - 5 - IDX_W;
  localparam int unsigned BEAT_W = 64;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = $clog2(LINE_BEATS);

  typedef enum logic [1:0] {IDLE, MISS_REQ, MISS_FILL, MISS_RESP} state_e;

  state_e               state_q, state_d;
  logic [31:0]          addr_q, addr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 cancel_q, cancel_d;
  logic                 resp_q, resp_d;
  logic [WORD_W-1:0]    rdata_q, rdata_d;
  logic                 bread_q, bread_d;
  logic [31:0]          baddr_q, baddr_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic                 fill_we;
  logic                 install;

  logic [BEAT_W-1:0] line_data_q [NUM_LINES][LINE_BEATS];
  logic [TAG_W-1:0]  line_tag_q  [NUM_LINES];

  // Field split of the incoming and the captured address
  logic [IDX_W-1:0]  req_idx, cap_idx;
  logic [TAG_W-1:0]  req_tag, cap_tag;
  logic [CNT_W-1:0]  req_beat, cap_beat;
  logic              req_half, cap_half;
  logic              req_hit;
  logic [BEAT_W-1:0] req_line_beat;
  logic [WORD_W-1:0] req_word;

  assign req_idx  = imem_addr[5 +: IDX_W];
  assign req_tag  = imem_addr[31 -: TAG_W];
  assign req_beat = imem_addr[4:3];
  assign req_half = imem_addr[2];
  assign cap_idx  = addr_q[5 +: IDX_W];
  assign cap_tag  = addr_q[31 -: TAG_W];
  assign cap_beat = addr_q[4:3];
  assign cap_half = addr_q[2];

  assign req_hit       = valid_q[req_idx] && (line_tag_q[req_idx] == req_tag);
  assign req_line_beat = line_data_q[req_idx][req_beat];
  assign req_word      = req_half ? req_line_beat[63:32] : req_line_beat[31:0];

`ifndef IMEM_CRITICAL_WORD_EN
  logic [BEAT_W-1:0] cap_line_beat;
  logic [WORD_W-1:0] cap_word;
  assign cap_line_beat = line_data_q[cap_idx][cap_beat];
  assign cap_word      = cap_half ? cap_line_beat[63:32] : cap_line_beat[31:0];
`endif

  // Byte-offset bits are don't-care for word fetches
  logic unused_addr_bits;
  assign unused_addr_bits = ^{imem_addr[1:0], addr_q[1:0]};

  // Next-state and output logic
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    cancel_d = cancel_q | flush;
    resp_d   = 1'b0;
    rdata_d  = rdata_q;
    bread_d  = bread_q;
    baddr_d  = baddr_q;
    valid_d  = valid_q;
    fill_we  = 1'b0;
    install  = 1'b0;
    case (state_q)
      IDLE: begin
        if ((imem_rmask != 4'b0000) && !flush) begin
          addr_d   = imem_addr;
          cancel_d = 1'b0;
          if (req_hit) begin
            resp_d  = 1'b1;
            rdata_d = req_word;
          end else begin
            state_d = MISS_REQ;
            bread_d = 1'b1;
            baddr_d = {imem_addr[31:5], 5'b00000};
          end
        end
      end
      MISS_REQ: begin
        if (bmem_ready) begin
          bread_d = 1'b0;
          cnt_d   = '0;
          state_d = MISS_FILL;
        end
      end
      MISS_FILL: begin
        if (bmem_rvalid) begin
          fill_we = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
`ifdef IMEM_CRITICAL_WORD_EN
          // Forward the requested word straight from its beat
          if ((cnt_q == cap_beat) && !cancel_q && !flush) begin
            resp_d  = 1'b1;
            rdata_d = cap_half ? bmem_rdata[63:32] : bmem_rdata[31:0];
          end
`endif
          if (cnt_q == CNT_W'(LINE_BEATS - 1)) begin
            install          = 1'b1;
            valid_d[cap_idx] = 1'b1;
            cnt_d            = '0;
            state_d          = MISS_RESP;
          end
        end
      end
      MISS_RESP: begin
`ifndef IMEM_CRITICAL_WORD_EN
        if (!cancel_q && !flush) begin
          resp_d  = 1'b1;
          rdata_d = cap_word;
        end
`endif
        cancel_d = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      cancel_q <= 1'b0;
      resp_q   <= 1'b0;
      rdata_q  <= '0;
      bread_q  <= 1'b0;
      baddr_q  <= '0;
      valid_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      cancel_q <= cancel_d;
      resp_q   <= resp_d;
      rdata_q  <= rdata_d;
      bread_q  <= bread_d;
      baddr_q  <= baddr_d;
      valid_q  <= valid_d;
    end
  end

  // Line data and tags; validity alone decides whether an entry is usable
  always_ff @(posedge clk) begin
    if (rst && fill_we) line_data_q[cap_idx][cnt_q] <= bmem_rdata;
    if (rst && install) line_tag_q[cap_idx] <= cap_tag;
  end

  assign imem_resp  = resp_q;
  assign imem_rdata = rdata_q;
  assign bmem_read  = bread_q;
  assign bmem_addr  = baddr_q;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: fetch driver with a line-level cache model,
// banked-memory model with random ready/beat gaps, and a scoreboard monitor.
module tb_imem_responder;
  localparam int unsigned NUM_LINES = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic        flush;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic [31:0] bmem_addr;
  logic        bmem_read;
  logic        bmem_ready;
  logic [63:0] bmem_rdata;
  logic        bmem_rvalid;

  imem_responder #(.NUM_LINES(NUM_LINES), .LINE_BEATS(4)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rmask(imem_rmask),
    .flush(flush), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_ready(bmem_ready),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef IMEM_CRITICAL_WORD_EN
  localparam bit CW = 1'b1;
`else
  localparam bit CW = 1'b0;
`endif

  function automatic void check(input bit ok, input string name,
                                input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Backing memory contents: every word address maps to a distinct value
  function automatic logic [31:0] word_of(input logic [31:0] a);
    logic [6:0] hi;
    hi = a[31:25] ^ 7'h30;
    return {2'b00, a[24:2], 7'b0000000} ^ 32'h13 ^ {25'd0, hi};
  endfunction

  function automatic logic [63:0] beat_of(input logic [31:0] line, input int b);
    logic [31:0] lo;
    lo = {line[31:5], 5'b00000} + 32'(b * 8);
    return {word_of(lo + 32'd4), word_of(lo)};
  endfunction

  // Line-level model of the buffer contents
  bit          model_valid [NUM_LINES];
  logic [31:0] model_line  [NUM_LINES];

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 5) % 32'(NUM_LINES));
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return model_valid[idx_of(a)] && (model_line[idx_of(a)] == {a[31:5], 5'b00000});
  endfunction

  function automatic void model_install(input logic [31:0] a);
    model_valid[idx_of(a)] = 1'b1;
    model_line[idx_of(a)]  = {a[31:5], 5'b00000};
  endfunction

  // Scoreboard: expected words, popped on every DUT response
  logic [31:0] exp_q[$];

  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (imem_resp === 1'b1) begin
        if (exp_q.size() == 0) check(1'b0, "unexpected_resp", 64'(imem_rdata), 64'd0);
        else begin
          e = exp_q.pop_front();
          check(imem_rdata == e, "resp_data", 64'(imem_rdata), 64'(e));
        end
      end
    end
  end

  // Memory model: decides acceptance at negedge, drives beats at posedge+1
  logic [31:0] bursts[$];
  bit          accept;
  bit          mem_active = 1'b0;
  bit          mem_kill = 1'b0;
  int          mem_beat, mem_gap, last_beat_idx;
  int          mem_gap_fixed = -1;
  int          stray_n = 0;
  int          beat_cyc [4];
  logic [31:0] mem_line;

  function automatic int pick_gap();
    return (mem_gap_fixed >= 0) ? mem_gap_fixed : int'($urandom_range(0, 2));
  endfunction

  initial begin
    bmem_ready = 1'b0; bmem_rvalid = 1'b0; bmem_rdata = '0; last_beat_idx = -1;
    forever begin
      @(negedge clk);
      accept = (bmem_read === 1'b1) && bmem_ready && (rst === 1'b1);
      if (accept) begin
        bursts.push_back(bmem_addr);
        mem_line = bmem_addr;
      end
      @(posedge clk); #1;
      bmem_rvalid = 1'b0;
      bmem_rdata  = {$urandom, $urandom};
      if (mem_kill) begin mem_active = 1'b0; mem_kill = 1'b0; end
      if (accept) begin mem_active = 1'b1; mem_beat = 0; mem_gap = pick_gap(); end
      if (mem_active) begin
        if (mem_gap == 0) begin
          bmem_rvalid = 1'b1;
          bmem_rdata  = beat_of(mem_line, mem_beat);
          beat_cyc[mem_beat] = cyc;
          last_beat_idx = mem_beat;
          mem_beat++;
          if (mem_beat == 4) mem_active = 1'b0;
          else mem_gap = pick_gap();
        end else mem_gap--;
      end else if (stray_n > 0) begin
        bmem_rvalid = 1'b1;
        last_beat_idx = -1;
        stray_n--;
      end
      bmem_ready = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic settle();
    imem_rmask = 4'h0;
    for (int i = 0; i < 300 && mem_active; i++) step();
    step(); step();
  endtask

  task automatic wait_beat(input int k);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (bmem_rvalid && last_beat_idx == k) ok = 1'b1;
    end
    check(ok, "beat_wait", 64'(last_beat_idx), 64'(k));
  endtask

  task automatic present(input logic [31:0] a);
    imem_addr  = {a[31:2], 2'($urandom_range(0, 3))};
    imem_rmask = 4'hF;
  endtask

  // Normal fetch: checks hit latency, burst traffic and miss response timing
  task automatic fetch(input logic [31:0] a);
    bit hit;
    int lat, nb, exp_cyc;
    hit = model_hit(a);
    nb  = bursts.size();
    exp_q.push_back(word_of(a));
    present(a);
    lat = 0;
    do begin step(); lat++; end while (imem_resp !== 1'b1 && lat < 300);
    check(lat < 300, "resp_timeout", 64'(lat), 64'd0);
    if (hit) begin
      check(lat == 1, "hit_latency", 64'(lat), 64'd1);
      check(bursts.size() == nb, "hit_no_burst", 64'(bursts.size()), 64'(nb));
    end else begin
      check(bursts.size() == nb + 1, "miss_burst_count", 64'(bursts.size()), 64'(nb + 1));
      if (bursts.size() > 0)
        check(bursts[bursts.size() - 1] == {a[31:5], 5'b00000}, "miss_burst_addr",
              64'(bursts[bursts.size() - 1]), 64'({a[31:5], 5'b00000}));
      exp_cyc = CW ? beat_cyc[int'(a[4:3])] + 1 : beat_cyc[3] + 2;
      check(cyc == exp_cyc, "miss_resp_cycle", 64'(cyc), 64'(exp_cyc));
      model_install(a);
      settle();
    end
  endtask

  // Miss cancelled by a flush at beat k (k==4: the cycle after the last beat)
  task automatic flush_miss(input logic [31:0] a, input int k);
    if (CW && int'(a[4:3]) < k) exp_q.push_back(word_of(a));
    present(a);
    wait_beat(k == 4 ? 3 : k);
    if (k == 4) @(negedge clk);
    flush = 1'b1;
    imem_rmask = 4'h0;
    step();
    flush = 1'b0;
    model_install(a);
    settle();
  endtask

  // Request presented together with flush must not be accepted
  task automatic flush_req(input logic [31:0] a);
    present(a);
    flush = 1'b1;
    step();
    flush = 1'b0;
    imem_rmask = 4'h0;
    check(imem_resp == 1'b0, "flush_blocks_accept", 64'(imem_resp), 64'd0);
    step(); step();
    check(bmem_read == 1'b0, "flush_no_burst", 64'(bmem_read), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check(imem_resp == 1'b0, {tag, "_resp"}, 64'(imem_resp), 64'd0);
    check(imem_rdata == 32'd0, {tag, "_rdata"}, 64'(imem_rdata), 64'd0);
    check(bmem_read == 1'b0, {tag, "_bmem_read"}, 64'(bmem_read), 64'd0);
    check(bmem_addr == 32'd0, {tag, "_bmem_addr"}, 64'(bmem_addr), 64'd0);
  endtask

  // Reset after beat 2 of a miss, then stray beats from the dead burst
  task automatic reset_mid_fill(input logic [31:0] a);
    present(a);
    wait_beat(2);
    mem_kill = 1'b1;
    step();
    rst = 1'b0;
    imem_rmask = 4'h0;
    step();
    rst = 1'b1;
    check_reset_outputs("mid_reset");
    for (int i = 0; i < NUM_LINES; i++) model_valid[i] = 1'b0;
    stray_n = 2;
    repeat (4) step();
    check(bmem_read == 1'b0, "stray_no_read", 64'(bmem_read), 64'd0);
    check(imem_resp == 1'b0, "stray_no_resp", 64'(imem_resp), 64'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] bases [4];
    bases = '{32'h6000_0000, 32'h6000_0080, 32'hA000_1000, 32'h0FFF_FF00};
    return bases[$urandom_range(0, 3)] + {23'd0, 7'($urandom_range(0, 31)), 2'b00};
  endfunction

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int r;
    rst = 1'b0; imem_addr = '0; imem_rmask = 4'h0; flush = 1'b0;
    for (int i = 0; i < NUM_LINES; i++) begin model_valid[i] = 1'b0; model_line[i] = '0; end
    repeat (3) step();
    check_reset_outputs("reset");
    rst = 1'b1;
    step();

    // Cold miss, then back-to-back hits in the same line
    fetch(32'h6000_0000);
    fetch(32'h6000_0004);
    fetch(32'h6000_0008);
    fetch(32'h6000_000C);
    imem_rmask = 4'h0;
    step();
    // Conflict eviction on the same index
    fetch(32'h6000_0080);
    fetch(32'h6000_0000);
    // Flush during beat 1, line still installed and then hit
    flush_miss(32'h6000_0020, 1);
    fetch(32'h6000_0024);
    imem_rmask = 4'h0;
    step();
    // Reset during fill; the line must miss again afterwards
    reset_mid_fill(32'h6000_00A0);
    fetch(32'h6000_0000);
    // Last-word miss with beats two cycles apart
    mem_gap_fixed = 1;
    fetch(32'h4000_0018);
    mem_gap_fixed = -1;
    flush_req(32'h4000_001C);
    fetch(32'h4000_001C);
    imem_rmask = 4'h0;
    step();

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      a = rand_addr();
      r = int'($urandom_range(0, 99));
      if (r < 8 && !model_hit(a)) flush_miss(a, int'($urandom_range(0, 4)));
      else if (r < 12) flush_req(a);
      else if (r < 14 && !model_hit(a)) reset_mid_fill(a);
      else begin
        fetch(a);
        if ($urandom_range(0, 3) == 0) begin imem_rmask = 4'h0; step(); end
      end
    end

    settle();
    repeat (3) step();
    check(exp_q.size() == 0, "scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-side responder for the fetch stage's imem request interface (imem_addr / imem_rmask in, imem_resp / imem_rdata out).
- Serves 32-bit instruction reads from a small direct-mapped line buffer.
- On a miss, issues a 4-beat x 64-bit burst read to banked backing memory, installs the line, then responds.
- Replaces the magic dual-port model on the instruction path once memory is integrated.

Parameters:
- NUM_LINES, 4, line-buffer entries; power of two, >=2; IDX_W = log2(NUM_LINES).
- LINE_BEATS, 4, beats per 32-byte line; fixed at 4 (BEAT_W = 64).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-low reset; rst==0 at a rising edge resets
- imem_addr  in  32  fetch byte address; [1:0] ignored
- imem_rmask  in  4  request valid when nonzero; only 4'b1111 used
- flush  in  1  branch redirect; cancels pending response
- imem_rdata  out  32  instruction word, valid only while imem_resp=1
- imem_resp  out  1  one-cycle response pulse
- bmem_addr  out  32  line-aligned burst address ([4:0]=0)
- bmem_read  out  1  burst request, held until accepted
- bmem_ready  in  1  memory accepts the request when high with bmem_read
- bmem_rdata  in  64  return beat
- bmem_rvalid  in  1  beat valid; beats arrive in order 0..3, possibly non-contiguously

Behaviour:
- Address split: word = addr[4:2], beat = addr[4:3], half = addr[2] (0 = low 32 bits), index = addr[5+:IDX_W], tag = addr[31:5+IDX_W].
- Reset: state IDLE; all valid bits 0; imem_resp=0, imem_rdata=0, bmem_read=0, bmem_addr=0; beat counter 0; pending-response flags cleared.
- States: IDLE, MISS_REQ, MISS_FILL, MISS_RESP.
- IDLE, request accepted when rmask!=0 and flush=0; addr captured.
  - Hit: imem_resp=1 next cycle with the selected word (1-cycle latency); stay IDLE.
  - A new request may be accepted in the same cycle as a hit resp (back-to-back hits, one resp per cycle).
  - Miss: go to MISS_REQ.
- MISS_REQ: bmem_read=1, bmem_addr={captured[31:5],5'b0}. On bmem_ready=1: drop bmem_read the next cycle and go to MISS_FILL.
- MISS_FILL: each bmem_rvalid writes bmem_rdata into beat slot[cnt] and increments cnt. On the 4th beat: write tag, set valid, cnt=0, go to MISS_RESP.
- MISS_RESP: imem_resp=1 for one cycle with the word from the filled line (unless cancelled); go to IDLE.
- Outside IDLE, imem_addr/imem_rmask are ignored. Fetch holds the request stable until resp; the captured address is authoritative.
- bmem_rvalid in IDLE or MISS_REQ is ignored (no write, no count).
- Flush high in cycle N:
  - Suppresses any resp due at N+1 or later for requests accepted at or before N.
  - A request presented in cycle N is not accepted.
  - An in-flight fill still completes and installs the line; state returns to IDLE with no resp.
- A miss evicts the indexed entry unconditionally; there is no dirty state.
- Reset mid-fill: immediate return to IDLE with all valids cleared; beats still arriving from the abandoned burst are ignored.
- Never more than one outstanding burst.

Optional Feature:
- Macro: IMEM_CRITICAL_WORD_EN.
- Defined:
  - In MISS_FILL, resp is raised the cycle after the beat containing the requested word arrives (beat == captured addr[4:3]), with the word taken from that beat.
  - Remaining beats still fill; MISS_RESP issues no resp; the next request is accepted only after return to IDLE.
  - Flush suppression still applies.
- Undefined: resp only in MISS_RESP, after all 4 beats.

Test Plan:
- Cold miss: reset, rmask=F, addr=0x60000000; mem returns beats 0x0000009300000013, 0x0000019300000113, ... → one bmem_read to 0x60000000, resp after beat 3 with rdata=0x00000013; exactly one resp.
- Hit stream: then addr=0x60000004, 0x60000008, 0x6000000C back-to-back → resp each next cycle with 0x00000093, 0x00000113, 0x00000193; bmem_read stays 0.
- Conflict eviction (NUM_LINES=4): read 0x60000000, then 0x60000080 (same index), then 0x60000000 → three bursts; third resp = 0x00000013.
- Flush mid-fill: miss on 0x60000020, assert flush during beat 1 → no resp; line installed; later 0x60000024 hits with 1-cycle latency.
- Reset mid-fill: drop rst to 0 after beat 2, release, send 2 stray rvalids → no resp, bmem_read=0, state IDLE; next 0x60000000 misses.
- With IMEM_CRITICAL_WORD_EN: miss on 0x60000018, beats spaced 2 cycles apart → resp the cycle after beat 3; without the macro, resp the cycle after MISS_RESP entry; rdata identical in both builds.
